branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
// PURPOSE
//   ID-stage branch/jump resolution; consumes EQ/GZ/LZ/GEZ/LEZ flags from the register comparator.
//   Decides taken/not-taken, computes target and link address, and tracks the delay slot.
//   Issues one registered PC redirect to IF after the delay-slot instruction is accepted,
//   or annuls that slot for a not-taken branch-likely. Registered outputs break the
//   compare->PC-mux timing path.
// PARAMETERS
//   RESET_PC  32'hBFC0_0000  value of redirect_pc after reset (no functional effect while redirect_valid=0)
// PORTS
//   clock        in   1   rising-edge clock
//   reset_n      in   1   asynchronous active-low reset
//   flush        in   1   exception flush; abandons any pending redirect/annul
//   stall        in   1   ID stalled; no branch or delay slot is accepted this cycle
//   br_valid     in   1   ID holds a branch/jump with valid operands
//   br_op        in   4   0 NONE,1 BEQ,2 BNE,3 BGTZ,4 BLEZ,5 BLTZ,6 BGEZ,7 BLTZAL,8 BGEZAL,9 J,10 JAL,11 JR,12 JALR; 13-15 = NONE
//   br_likely    in   1   branch-likely variant (valid with ops 1-8 only)
//   pc_plus4     in   32  address of branch + 4
//   imm_off      in   16  branch offset (words, signed)
//   j_index      in   26  J/JAL instruction index
//   rs_value     in   32  forwarded rs (JR/JALR target)
//   EQ,GZ,LZ,GEZ,LEZ in 1 each  comparator flags for current ID operands
//   ds_valid     in   1   IF presents the delay-slot instruction this cycle
//   redirect_valid out 1  one-cycle pulse: IF loads redirect_pc
//   redirect_pc  out  32  resolved target
//   annul_ds     out  1   one-cycle pulse: squash delay-slot instruction as it enters ID
//   link_we      out  1   one-cycle pulse: write link_addr to $31 (or rd for JALR)
//   link_addr    out  32  pc_plus4 + 4
//   addr_err     out  1   one-cycle pulse: JR/JALR taken with rs_value[1:0]!=0
//   busy         out  1   1 in any state other than IDLE
// BEHAVIOUR
//   Reset: state IDLE; all pulse outputs 0; redirect_pc=RESET_PC; link_addr=0.
//   Accept = br_valid & ~stall & ~flush & state==IDLE & br_op in 1..12.
//   Taken: BEQ EQ; BNE ~EQ; BGTZ GZ; BLEZ LEZ; BLTZ/BLTZAL LZ; BGEZ/BGEZAL GEZ; ops 9-12 always.
//   Target (mod 2^32): branch pc_plus4+{{14{imm_off[15]}},imm_off,2'b00};
//     J/JAL {pc_plus4[31:28],j_index,2'b00}; JR/JALR rs_value. Target is latched at accept.
//   Link: ops 7,8,10,12 assert link_we the cycle after accept, regardless of taken; link_addr=pc_plus4+4.
//   FSM:
//     IDLE:   accept & taken & ds_valid -> redirect_valid next cycle, stay IDLE.
//             accept & taken & ~ds_valid -> WAIT_DS.
//             accept & ~taken & br_likely & ds_valid -> annul_ds next cycle, stay IDLE.
//             accept & ~taken & br_likely & ~ds_valid -> ANNUL_DS.
//             accept & ~taken & ~br_likely -> no action.
//     WAIT_DS:  ds_valid & ~stall -> redirect_valid next cycle, -> IDLE. Else hold.
//     ANNUL_DS: ds_valid & ~stall -> annul_ds next cycle, -> IDLE. Else hold.
//   br_valid while busy (branch in delay slot) is ignored; no second redirect is produced.
//   JR/JALR with rs_value[1:0]!=0: addr_err pulses the cycle after accept; redirect still issued
//     (the exception unit flushes).
//   flush has priority over everything: state -> IDLE; all pulses 0 next cycle;
//     a same-cycle accept is dropped. A reset mid-WAIT_DS drops the redirect.
//   Pulses are single-cycle registered; latency accept->redirect is >= 1 cycle.
// TESTING
//   BEQ EQ=1, pc_plus4=0x0040_0004, imm_off=0xFFFF, ds_valid=1 -> redirect_valid next cycle, redirect_pc=0x0040_0000.
//   BNE EQ=1 -> no redirect, no annul; BNEL EQ=1, ds_valid=0 for 2 cycles then 1 -> annul_ds 1 cycle later, busy=1 meanwhile.
//   JAL pc_plus4=0x8000_0104, j_index=0x0000040 -> redirect_pc=0x8000_0100, link_we=1, link_addr=0x8000_0108.
//   JR rs_value=0x0000_1002 -> addr_err=1 and redirect_pc=0x0000_1002 in the same cycle.
//   Taken BGEZ into WAIT_DS, flush=1 -> no redirect ever; a second branch while busy is ignored.
//   Offset wrap: pc_plus4=0xFFFF_FFFC, imm_off=0x0001 -> redirect_pc=0x0000_0000; reset_n low mid-WAIT_DS -> outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch/jump resolution with registered PC redirect, delay-slot annul and link write.
module branch_resolve #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [3:0]  br_op_i,
  input  logic        br_likely_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [15:0] imm_off_i,
  input  logic [25:0] j_index_i,
  input  logic [31:0] rs_value_i,
  input  logic        eq_i,
  input  logic        gz_i,
  input  logic        lz_i,
  input  logic        gez_i,
  input  logic        lez_i,
  input  logic        ds_valid_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        annul_ds_o,
  output logic        link_we_o,
  output logic [31:0] link_addr_o,
  output logic        addr_err_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT_DS, ANNUL_DS} state_t;
  state_t      state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        annul_q, annul_d;
  logic        link_we_q, link_we_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        accept, taken, likely, is_jr, ds_go;
  logic [31:0] br_tgt, target;
  assign accept = br_valid_i & ~stall_i & ~flush_i & (state_q == IDLE)
                & (br_op_i >= 4'd1) & (br_op_i <= 4'd12);
  assign taken  = ((br_op_i == 4'd1) & eq_i) | ((br_op_i == 4'd2) & ~eq_i)
                | ((br_op_i == 4'd3) & gz_i) | ((br_op_i == 4'd4) & lez_i)
                | (((br_op_i == 4'd5) | (br_op_i == 4'd7)) & lz_i)
                | (((br_op_i == 4'd6) | (br_op_i == 4'd8)) & gez_i)
                | (br_op_i >= 4'd9);
  assign likely = br_likely_i & (br_op_i <= 4'd8);
  assign is_jr  = (br_op_i == 4'd11) | (br_op_i == 4'd12);
  assign br_tgt = pc_plus4_i + {{14{imm_off_i[15]}}, imm_off_i, 2'b00};
  assign target = (br_op_i <= 4'd8) ? br_tgt
                : (br_op_i <= 4'd10) ? {pc_plus4_i[31:28], j_index_i, 2'b00} : rs_value_i;
  assign ds_go  = ds_valid_i & ~stall_i & ~flush_i;
  // The target is latched at accept so redirect_pc is already stable while waiting for the delay slot.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    annul_d          = 1'b0;
    link_we_d        = 1'b0;
    addr_err_d       = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    link_addr_d      = link_addr_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (accept) begin
        redirect_pc_d    = target;
        link_addr_d      = pc_plus4_i + 32'd4;
        link_we_d        = (br_op_i == 4'd7) | (br_op_i == 4'd8) | (br_op_i == 4'd10) | (br_op_i == 4'd12);
        addr_err_d       = is_jr & (rs_value_i[1:0] != 2'b00);
        redirect_valid_d = taken & ds_valid_i;
        annul_d          = ~taken & likely & ds_valid_i;
        state_d          = (taken & ~ds_valid_i) ? WAIT_DS
                         : (~taken & likely & ~ds_valid_i) ? ANNUL_DS : IDLE;
      end
    end else if (ds_go) begin
      redirect_valid_d = (state_q == WAIT_DS);
      annul_d          = (state_q == ANNUL_DS);
      state_d          = IDLE;
    end
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      annul_q          <= 1'b0;
      link_we_q        <= 1'b0;
      addr_err_q       <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      link_addr_q      <= 32'd0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      annul_q          <= annul_d;
      link_we_q        <= link_we_d;
      addr_err_q       <= addr_err_d;
      redirect_pc_q    <= redirect_pc_d;
      link_addr_q      <= link_addr_d;
    end
  end
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign annul_ds_o       = annul_q;
  assign link_we_o        = link_we_q;
  assign link_addr_o      = link_addr_q;
  assign addr_err_o       = addr_err_q;
  assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench; a reference model predicts pulse events, a monitor pops and compares them.
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall, br_valid, br_likely, ds_valid;
  logic [3:0]  br_op;
  logic [31:0] pc_plus4, rs_value;
  logic [15:0] imm_off;
  logic [25:0] j_index;
  logic        eq, gz, lz, gez, lez;
  logic        redirect_valid, annul_ds, link_we, addr_err, busy;
  logic [31:0] redirect_pc, link_addr;
  always #5 clk = ~clk;
  branch_resolve dut (
    .clock_i(clk), .reset_n_i(rst_n), .flush_i(flush), .stall_i(stall),
    .br_valid_i(br_valid), .br_op_i(br_op), .br_likely_i(br_likely),
    .pc_plus4_i(pc_plus4), .imm_off_i(imm_off), .j_index_i(j_index), .rs_value_i(rs_value),
    .eq_i(eq), .gz_i(gz), .lz_i(lz), .gez_i(gez), .lez_i(lez), .ds_valid_i(ds_valid),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .annul_ds_o(annul_ds),
    .link_we_o(link_we), .link_addr_o(link_addr), .addr_err_o(addr_err), .busy_o(busy)
  );
  typedef struct {
    int          cyc;
    logic        rv;
    logic [31:0] pc;
    logic        an;
    logic        lw;
    logic [31:0] la;
    logic        ae;
  } exp_t;
  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          pend = 0;
  logic [31:0] pend_pc = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, req, cyc);
    end
  endtask
  // Monitor: every observed pulse must match the oldest predicted event for this cycle.
  always @(negedge clk) if (rst_n) begin
    while (q.size() != 0 && q[0].cyc < cyc) begin
      chk("missed_event_cycle", 32'(cyc), 32'(q[0].cyc));
      void'(q.pop_front());
    end
    if (redirect_valid | annul_ds | link_we | addr_err) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        chk("unexpected_pulse", {28'd0, redirect_valid, annul_ds, link_we, addr_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        chk("annul_ds", 32'(annul_ds), 32'(e.an));
        chk("link_we", 32'(link_we), 32'(e.lw));
        chk("addr_err", 32'(addr_err), 32'(e.ae));
        if (e.rv | e.ae) chk("redirect_pc", redirect_pc, e.pc);
        if (e.lw) chk("link_addr", link_addr, e.la);
      end
    end
  end
  // One clock of stimulus: comparator flags come from real operand values a (rs) and b (rt).
  task automatic drive(input bit bv, input logic [3:0] op, input bit lk, input logic [31:0] p4,
                       input logic [15:0] imm, input logic [25:0] ji, input logic [31:0] rs,
                       input int a, input int b, input bit ds, input bit st, input bit fl);
    exp_t        e;
    logic [31:0] tgt;
    bit          tk;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(pend != 0));
    br_valid = bv; br_op = op; br_likely = lk; pc_plus4 = p4; imm_off = imm; j_index = ji;
    rs_value = rs; ds_valid = ds; stall = st; flush = fl;
    eq = (a == b); gz = (a > 0); lz = (a < 0); gez = (a >= 0); lez = (a <= 0);
    e.cyc = cyc + 1; e.rv = 0; e.pc = '0; e.an = 0; e.lw = 0; e.la = '0; e.ae = 0;
    if (fl) pend = 0;
    else if (pend != 0) begin
      if (ds && !st) begin
        if (pend == 1) begin e.rv = 1; e.pc = pend_pc; end
        else e.an = 1;
        pend = 0;
      end
    end else if (bv && !st && op >= 1 && op <= 12) begin
      if (op <= 8) tgt = p4 + 32'(int'($signed(imm)) * 4);
      else if (op <= 10) tgt = {p4[31:28], ji, 2'b00};
      else tgt = rs;
      case (op)
        1: tk = (a == b);
        2: tk = (a != b);
        3: tk = (a > 0);
        4: tk = (a <= 0);
        5, 7: tk = (a < 0);
        6, 8: tk = (a >= 0);
        default: tk = 1;
      endcase
      e.la = p4 + 4;
      e.lw = (op == 7 || op == 8 || op == 10 || op == 12);
      e.ae = (op == 11 || op == 12) && rs[1:0] != 0;
      e.pc = tgt;
      if (tk) begin
        if (ds) e.rv = 1;
        else begin pend = 1; pend_pc = tgt; end
      end else if (lk && op <= 8) begin
        if (ds) e.an = 1;
        else pend = 2;
      end
    end
    if (e.rv | e.an | e.lw | e.ae) q.push_back(e);
  endtask
  task automatic idle(input bit ds);
    drive(0, 4'd0, 0, 32'd0, 16'd0, 26'd0, 32'd0, 1, 2, ds, 0, 0);
  endtask
  initial begin
    rst_n = 0; flush = 0; stall = 0; br_valid = 0; br_op = 0; br_likely = 0; ds_valid = 0;
    pc_plus4 = 0; imm_off = 0; j_index = 0; rs_value = 0; eq = 0; gz = 0; lz = 0; gez = 0; lez = 0;
    repeat (2) @(negedge clk);
    chk("reset_redirect_pc", redirect_pc, 32'hBFC0_0000);
    chk("reset_link_addr", link_addr, 32'd0);
    chk("reset_pulses", {28'd0, redirect_valid, annul_ds, link_we, addr_err}, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1;
    // BEQ taken backwards by one word
    drive(1, 4'd1, 0, 32'h0040_0004, 16'hFFFF, 26'd0, 32'd0, 5, 5, 1, 0, 0);
    idle(0);
    chk("beq_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("beq_redirect_pc", redirect_pc, 32'h0040_0000);
    // BNE not taken, then BNEL annul after delayed delay slot
    drive(1, 4'd2, 0, 32'h0000_1000, 16'h0010, 26'd0, 32'd0, 3, 3, 1, 0, 0);
    drive(1, 4'd2, 1, 32'h0000_2000, 16'h0010, 26'd0, 32'd0, 3, 3, 0, 0, 0);
    idle(0);
    idle(0);
    chk("bnel_busy", 32'(busy), 32'd1);
    idle(1);
    idle(0);
    chk("bnel_annul", 32'(annul_ds), 32'd1);
    // JAL
    drive(1, 4'd10, 0, 32'h8000_0104, 16'd0, 26'h0000040, 32'd0, 0, 0, 1, 0, 0);
    idle(0);
    chk("jal_redirect_pc", redirect_pc, 32'h8000_0100);
    chk("jal_link_addr", link_addr, 32'h8000_0108);
    chk("jal_link_we", 32'(link_we), 32'd1);
    // JR misaligned
    drive(1, 4'd11, 0, 32'h0000_0040, 16'd0, 26'd0, 32'h0000_1002, 0, 0, 1, 0, 0);
    idle(0);
    chk("jr_addr_err", 32'(addr_err), 32'd1);
    chk("jr_redirect_pc", redirect_pc, 32'h0000_1002);
    // BGEZ into WAIT_DS, second branch ignored, then flush
    drive(1, 4'd6, 0, 32'h0000_3000, 16'h0004, 26'd0, 32'd0, 0, 0, 0, 0, 0);
    drive(1, 4'd9, 0, 32'h0000_3004, 16'd0, 26'h123, 32'd0, 0, 0, 0, 0, 0);
    drive(0, 4'd0, 0, 32'd0, 16'd0, 26'd0, 32'd0, 0, 0, 1, 0, 1);
    idle(1);
    idle(1);
    // Offset wrap
    drive(1, 4'd1, 0, 32'hFFFF_FFFC, 16'h0001, 26'd0, 32'd0, 7, 7, 1, 0, 0);
    idle(0);
    chk("wrap_redirect_pc", redirect_pc, 32'h0000_0000);
    // Reset while waiting for the delay slot
    drive(1, 4'd3, 0, 32'h0000_5000, 16'h0008, 26'd0, 32'd0, 4, 0, 0, 0, 0);
    idle(0);
    #2 rst_n = 0;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_pc", redirect_pc, 32'hBFC0_0000);
    pend = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1;
    idle(1);
    idle(1);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom,
            16'($urandom), 26'($urandom), $urandom, int'($urandom_range(0, 4)) - 2,
            int'($urandom_range(0, 2)) - 1, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0);
    end
    repeat (4) idle(1);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
